// File: rtl/bv4_sq_scl_pipe.sv
// Multi-lane GF(2^4) square / square-scale-by-s unit with a stallable valid/ready pipeline.
// Sits between the GF(2^8) inversion front end and the GF(2^4) inverter of the tower-field S-box.
module bv4_sq_scl_pipe #(
    parameter int LANES   = 4,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 8
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic                 in_a_valid,
    output logic                 out_a_ready,
    input  logic [4*LANES-1:0]   in_a,
    input  logic [1:0]           in_mode,
    output logic [4*LANES-1:0]   out_b,
    output logic                 out_b_err,
    output logic                 out_b_valid,
    input  logic                 in_b_ready,
    output logic [COUNT_W-1:0]   out_count
);

    localparam int W = 4 * LANES;

    function automatic logic [1:0] bv2_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // Scaling by Sigma^2 in the normal-basis GF(2^2) subfield.
    function automatic logic [1:0] bv2_scl_sigma2(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic logic [3:0] bv4_sq_scl_s(input logic [3:0] a);
        logic [1:0] s1;
        logic [1:0] s0;
        s1 = bv2_sq(a[3:2]);
        s0 = bv2_sq(a[1:0]);
        return {s0 ^ s1, bv2_scl_sigma2(s0)};
    endfunction

    logic [W-1:0]      stage_in_data;
    logic              stage_in_err;

    logic [STAGES-1:0] slot_valid;
    logic [STAGES-1:0] slot_err;
    logic [W-1:0]      slot_data [STAGES];

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_err;
    logic [W-1:0]      up_data [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              space;

    always_comb begin
        stage_in_data = '0;
        stage_in_err  = (in_mode == 2'b11);
        for (int i = 0; i < LANES; i++) begin
            case (in_mode)
                2'b00:   stage_in_data[4*i +: 4] = in_a[4*i +: 4];
                2'b01:   stage_in_data[4*i +: 4] = {bv2_sq(in_a[4*i+2 +: 2]), bv2_sq(in_a[4*i +: 2])};
                2'b10:   stage_in_data[4*i +: 4] = bv4_sq_scl_s(in_a[4*i +: 4]);
                default: stage_in_data[4*i +: 4] = 4'h0;
            endcase
        end
    end

    // Backward ready chain: a slot may load when it is empty or is itself moving on.
    always_comb begin
        adv   = '0;
        load  = '0;
        space = in_b_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = slot_valid[k] && space;
            load[k] = !slot_valid[k] || space;
            space   = load[k];
        end
    end

    assign out_a_ready = load[0];

    always_comb begin
        up_valid[0] = in_a_valid;
        up_err[0]   = stage_in_err;
        up_data[0]  = stage_in_data;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = slot_valid[k-1];
            up_err[k]   = slot_err[k-1];
            up_data[k]  = slot_data[k-1];
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            slot_valid <= '0;
            slot_err   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    slot_valid[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        slot_data[k] <= up_data[k];
                        slot_err[k]  <= up_err[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_count <= '0;
        end else if (adv[STAGES-1]) begin
            out_count <= out_count + 1'b1;
        end
    end

    assign out_b       = slot_data[STAGES-1];
    assign out_b_err   = slot_err[STAGES-1];
    assign out_b_valid = slot_valid[STAGES-1];

endmodule

// File: tb/tb_bv4_sq_scl_pipe.sv
// Directed bench for bv4_sq_scl_pipe: vector table, back-to-back, stall, reset and wrap sequences.
// Expected results come from hand-computed constants and a table-based GF(2^2) reference model.
module tb_bv4_sq_scl_pipe;

    localparam int LANES   = 4;
    localparam int STAGES  = 2;
    localparam int COUNT_W = 8;
    localparam int N_VEC   = 10;
    localparam int N_STREAM = 260;

    logic                clock = 1'b0;
    logic                reset;
    logic                in_a_valid;
    logic                out_a_ready;
    logic [4*LANES-1:0]  in_a;
    logic [1:0]          in_mode;
    logic [4*LANES-1:0]  out_b;
    logic                out_b_err;
    logic                out_b_valid;
    logic                in_b_ready;
    logic [COUNT_W-1:0]  out_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] a;
        logic [15:0] exp_b;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] b;
        logic        err;
        int          cyc;
    } exp_t;

    vec_t vecs [N_VEC];
    exp_t exp_q [$];

    logic [1:0] sq_tab  [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [1:0] scl_tab [4] = '{2'd0, 2'd3, 2'd1, 2'd2};

    bv4_sq_scl_pipe #(.LANES(LANES), .STAGES(STAGES), .COUNT_W(COUNT_W)) dut (
        .in_clock    (clock),
        .in_reset    (reset),
        .in_a_valid  (in_a_valid),
        .out_a_ready (out_a_ready),
        .in_a        (in_a),
        .in_mode     (in_mode),
        .out_b       (out_b),
        .out_b_err   (out_b_err),
        .out_b_valid (out_b_valid),
        .in_b_ready  (in_b_ready),
        .out_count   (out_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] model(input logic [1:0] mode, input logic [15:0] a);
        logic [15:0] r;
        logic [1:0]  a1;
        logic [1:0]  a0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a1 = a[4*i+2 +: 2];
            a0 = a[4*i +: 2];
            case (mode)
                2'b00:   r[4*i +: 4] = {a1, a0};
                2'b01:   r[4*i +: 4] = {sq_tab[a1], sq_tab[a0]};
                2'b10:   r[4*i +: 4] = {sq_tab[a1] ^ sq_tab[a0], scl_tab[sq_tab[a0]]};
                default: r[4*i +: 4] = 4'h0;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] mode, input logic [15:0] a);
        in_a_valid = valid;
        in_mode    = mode;
        in_a       = a;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [COUNT_W-1:0] cnt_before;
        logic [15:0]        ra;
        logic [1:0]         rm;
        exp_t               e;

        vecs[0] = '{2'b01, 16'h4021, 16'h8012, 1'b0};
        vecs[1] = '{2'b00, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[2] = '{2'b10, 16'h4444, 16'h8888, 1'b0};
        vecs[3] = '{2'b11, 16'hFFFF, 16'h0000, 1'b1};
        vecs[4] = '{2'b10, 16'h0123, 16'h097E, 1'b0};
        vecs[5] = '{2'b10, 16'h4567, 16'h81F6, 1'b0};
        vecs[6] = '{2'b10, 16'h89AB, 16'h4D3A, 1'b0};
        vecs[7] = '{2'b10, 16'hCDEF, 16'hC5B2, 1'b0};
        vecs[8] = '{2'b01, 16'h89AB, 16'h4657, 1'b0};
        vecs[9] = '{2'b11, 16'h1234, 16'h0000, 1'b1};

        reset      = 1'b1;
        in_b_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, 16'h0);
        repeat (2) @(negedge clock);
        checkOutput("rst_valid", 32'(out_b_valid), 0);
        checkOutput("rst_b", 32'(out_b), 0);
        checkOutput("rst_err", 32'(out_b_err), 0);
        checkOutput("rst_count", 32'(out_count), 0);
        reset = 1'b0;
        next_cycle();
        checkOutput("rst_ready", 32'(out_a_ready), 1);

        // Isolated transactions: check latency, result and counter step for each vector.
        for (int i = 0; i < N_VEC; i++) begin
            cnt_before = out_count;
            applyStimulus(1'b1, vecs[i].mode, vecs[i].a);
            next_cycle();
            applyStimulus(1'b0, 2'b00, 16'h0);
            checkOutput("vec_early", 32'(out_b_valid), 0);
            next_cycle();
            checkOutput("vec_valid", 32'(out_b_valid), 1);
            checkOutput("vec_b", 32'(out_b), 32'(vecs[i].exp_b));
            checkOutput("vec_err", 32'(out_b_err), 32'(vecs[i].exp_err));
            checkOutput("vec_cnt_hold", 32'(out_count), 32'(cnt_before));
            next_cycle();
            checkOutput("vec_cnt_inc", 32'(out_count), 32'(COUNT_W'(cnt_before + 1'b1)));
            checkOutput("vec_drained", 32'(out_b_valid), 0);
        end

        applyStimulus(1'b1, 2'b00, 16'hBEEF);
        next_cycle();
        applyStimulus(1'b1, 2'b10, 16'h4444);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 16'h0);
        checkOutput("b2b_v0", 32'(out_b_valid), 1);
        checkOutput("b2b_b0", 32'(out_b), 32'h0000BEEF);
        next_cycle();
        checkOutput("b2b_v1", 32'(out_b_valid), 1);
        checkOutput("b2b_b1", 32'(out_b), 32'h00008888);
        next_cycle();
        checkOutput("b2b_end", 32'(out_b_valid), 0);

        // Stall: two accepted, third held off until downstream frees up.
        in_b_ready = 1'b0;
        applyStimulus(1'b1, 2'b01, 16'h4021);
        next_cycle();
        checkOutput("stall_rdy1", 32'(out_a_ready), 1);
        applyStimulus(1'b1, 2'b10, 16'h0123);
        next_cycle();
        checkOutput("stall_full", 32'(out_a_ready), 0);
        applyStimulus(1'b1, 2'b11, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checkOutput("stall_rdy0", 32'(out_a_ready), 0);
            checkOutput("stall_valid", 32'(out_b_valid), 1);
            checkOutput("stall_hold", 32'(out_b), 32'h00008012);
        end
        in_b_ready = 1'b1;
        #1;
        checkOutput("stall_release_rdy", 32'(out_a_ready), 1);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 16'h0);
        checkOutput("stall_b_second", 32'(out_b), 32'h0000097E);
        checkOutput("stall_v_second", 32'(out_b_valid), 1);
        next_cycle();
        checkOutput("stall_b_third", 32'(out_b), 0);
        checkOutput("stall_err_third", 32'(out_b_err), 1);
        checkOutput("stall_v_third", 32'(out_b_valid), 1);
        next_cycle();
        checkOutput("stall_no_dup", 32'(out_b_valid), 0);

        // Reset with two transactions in flight.
        applyStimulus(1'b1, 2'b01, 16'h1111);
        next_cycle();
        applyStimulus(1'b1, 2'b01, 16'h2222);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 16'h0);
        checkOutput("inflight_valid", 32'(out_b_valid), 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(out_b_valid), 0);
        checkOutput("midrst_count", 32'(out_count), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checkOutput("postrst_no_stale", 32'(out_b_valid), 0);
        end
        checkOutput("postrst_ready", 32'(out_a_ready), 1);

        // Full-rate stream from a fresh counter; 260 results wrap an 8-bit count to 4.
        for (int cyc = 0; cyc < N_STREAM + STAGES; cyc++) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc - STAGES) begin
                e = exp_q.pop_front();
                checkOutput("stream_valid", 32'(out_b_valid), 1);
                checkOutput("stream_b", 32'(out_b), 32'(e.b));
                checkOutput("stream_err", 32'(out_b_err), 32'(e.err));
            end else begin
                checkOutput("stream_idle", 32'(out_b_valid), 0);
            end
            if (cyc < N_STREAM) begin
                checkOutput("stream_ready", 32'(out_a_ready), 1);
                ra = 16'($urandom);
                rm = 2'($urandom_range(0, 3));
                applyStimulus(1'b1, rm, ra);
                e.b   = model(rm, ra);
                e.err = (rm == 2'b11);
                e.cyc = cyc;
                exp_q.push_back(e);
            end else begin
                applyStimulus(1'b0, 2'b00, 16'h0);
            end
            next_cycle();
        end
        checkOutput("stream_leftover", 32'(exp_q.size()), 0);
        checkOutput("stream_wrap", 32'(out_count), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bv4_sq_scl_pipe.md
Name: bv4_sq_scl_pipe

Overview:
Pipelined, multi-lane successor to the combinational GF(2^4) square-and-scale block used in the tower-field AES S-box datapath. Each transaction carries LANES nibbles and a per-transaction mode: bypass, square, or square-and-scale by s = Sigma^2 * Z. Results leave through a registered valid/ready pipeline of depth STAGES with stall support and a transaction counter. It sits between the GF(2^8) inversion front end and the GF(2^4) inverter.

Parameters:
LANES, 4, number of independent bv4 lanes per transaction (1..16)
STAGES, 2, register stages between input handshake and output (1..4)
COUNT_W, 8, width of the completed-transaction counter

Ports:
in_clock  input  1  clock, rising edge
in_reset  input  1  asynchronous active-high reset
in_a_valid  input  1  input transaction valid
out_a_ready  output  1  block can accept an input transaction this cycle
in_a  input  4*LANES  lane i in bits [4i+3:4i]; each nibble is {a1,a0} as bv2_t[1:0]
in_mode  input  2  00 bypass, 01 square, 10 square-scale-s, 11 illegal
out_b  output  4*LANES  result lanes, same packing as in_a
out_b_err  output  1  result slot was produced from in_mode=11
out_b_valid  output  1  out_b/out_b_err valid
in_b_ready  input  1  downstream accepts result
out_count  output  COUNT_W  number of completed output handshakes, modulo 2^COUNT_W

Behaviour:
- Arithmetic per lane (combinational, ahead of stage-0 register), using bv2_sq (bit swap: {x0,x1}) and bv2_scl_sigma2:
  - mode 00: b = a
  - mode 01: b1 = sq(a1), b0 = sq(a0)
  - mode 10: b1 = sq(a0) ^ sq(a1), b0 = scl_sigma2(sq(a0)); must equal existing combinational square-scale-s function bit for bit
  - mode 11: b = 4'h0 on all lanes, err bit = 1 carried with the slot; all other modes carry err = 0
- Pipeline: STAGES slots, each {valid, data[4*LANES], err}. Slot k captures from slot k-1 (slot 0 from input) when slot k is empty or slot k itself advances this cycle.
- Output: slot STAGES-1 drives out_b, out_b_err, out_b_valid. Output advances on out_b_valid && in_b_ready.
- out_a_ready = !valid[0] || slot 0 advances this cycle (combinational backward ready chain); full throughput of one transaction/cycle with in_b_ready held high.
- Input handshake: in_a_valid && out_a_ready. in_a/in_mode sampled only on handshake; changes while not ready are ignored.
- Latency: handshake in cycle t -> out_b_valid in cycle t+STAGES with no stall. Stalls never drop, duplicate or reorder transactions. out_b holds stable while out_b_valid && !in_b_ready.
- Full: all slots valid and in_b_ready=0 -> out_a_ready=0. Simultaneous drain and fill on a full pipe is accepted in the same cycle (no bubble).
- Empty: out_b_valid=0; out_b holds last value, don't-care to checkers.
- out_count increments by 1 on each output handshake; wraps 2^COUNT_W-1 -> 0 without flag. Illegal-mode results are counted.
- Reset (async assert, sync-safe release): all slot valids 0, out_b=0, out_b_err=0, out_b_valid=0, out_count=0; out_a_ready=1 from first cycle after release. Reset mid-operation drops all in-flight transactions.
- No X propagation from data into valids; valid bits reset, data regs reset to 0.

Test Plan:
- Reset then single transaction, LANES=4, STAGES=2, mode 01, in_a=16'h4021 -> cycle t+2: out_b=16'h8012, out_b_err=0, out_count 0->1 on handshake.
- Mode 00 with in_a=16'hBEEF, then mode 10 with in_a=16'h4444 (a0=0) back-to-back -> outputs 16'hBEEF then 16'h8888 in consecutive cycles; mode 10 results match existing square-scale-s model for all 16 nibble values.
- Mode 11 with in_a=16'hFFFF -> out_b=16'h0000, out_b_err=1, out_count still increments.
- Fill pipe with 3 transactions, in_b_ready=0 for 5 cycles -> out_a_ready=0 after 2 accepted, out_b stable; release ready -> remaining results in order, no loss or duplicate.
- Continuous stream with in_b_ready=1, COUNT_W=8, 260 transactions -> out_count wraps to 4; one transaction/cycle throughput.
- Assert in_reset with 2 transactions in flight -> out_b_valid=0, out_count=0 immediately; no stale result appears after release.
